// File: rtl/regfile_writeback_arbiter.sv
// Round-robin ALU/LSU writeback arbiter driving the register-file write port.
// Define WB_SCOREBOARD_EN to add the pending-write busy-bit scoreboard.
module regfile_writeback_arbiter #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int PATTERN_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_wb_valid,
  output logic                     alu_wb_ready,
  input  logic [ADDR_WIDTH-1:0]    alu_wb_rd,
  input  logic [DATA_WIDTH-1:0]    alu_wb_data,
  input  logic [PATTERN_WIDTH-1:0] alu_wb_pattern,
  input  logic                     lsu_wb_valid,
  output logic                     lsu_wb_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_wb_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_wb_data,
  input  logic [PATTERN_WIDTH-1:0] lsu_wb_pattern,
  input  logic                     issue_valid,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  output logic                     issue_ready,
  input  logic [ADDR_WIDTH-1:0]    rs1,
  input  logic [ADDR_WIDTH-1:0]    rs2,
  output logic                     hazard_a,
  output logic                     hazard_b,
  output logic                     wr_enable,
  output logic [ADDR_WIDTH-1:0]    wr_address,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [PATTERN_WIDTH-1:0] write_pattern
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_t;

  src_t last_grant;

  logic                     alu_go;
  logic                     lsu_go;
  logic                     wb_go;
  logic [ADDR_WIDTH-1:0]    wb_rd;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic [PATTERN_WIDTH-1:0] wb_pat;

  // Grant depends only on the valids, never on the other ready.
  assign alu_wb_ready = !reset && alu_wb_valid &&
                        (!lsu_wb_valid || last_grant == SRC_LSU);
  assign lsu_wb_ready = !reset && lsu_wb_valid &&
                        (!alu_wb_valid || last_grant == SRC_ALU);

  assign alu_go = alu_wb_valid && alu_wb_ready;
  assign lsu_go = lsu_wb_valid && lsu_wb_ready;
  assign wb_go  = alu_go || lsu_go;

  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    wb_pat  = '0;
    unique case (1'b1)
      alu_go: begin
        wb_rd   = alu_wb_rd;
        wb_data = alu_wb_data;
        wb_pat  = alu_wb_pattern;
      end
      lsu_go: begin
        wb_rd   = lsu_wb_rd;
        wb_data = lsu_wb_data;
        wb_pat  = lsu_wb_pattern;
      end
      default: ;
    endcase
  end

  // Writes to x0 are accepted but dropped; the port keeps its last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_enable     <= 1'b0;
      wr_address    <= '0;
      wr_data       <= '0;
      write_pattern <= '0;
      last_grant    <= SRC_LSU;
    end else begin
      wr_enable <= wb_go && (wb_rd != '0);
      if (wb_go && (wb_rd != '0)) begin
        wr_address    <= wb_rd;
        wr_data       <= wb_data;
        write_pattern <= wb_pat;
      end
      if (alu_go)
        last_grant <= SRC_ALU;
      else if (lsu_go)
        last_grant <= SRC_LSU;
    end
  end

`ifdef WB_SCOREBOARD_EN
  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:1] busy;
  logic [NREG-1:0] busy_all;
  logic [NREG-1:0] busy_nx;
  logic            unused_bit0;

  // Bit 0 is tied low so x0 is never busy.
  assign busy_all    = {busy, 1'b0};
  assign issue_ready = !busy_all[issue_rd];
  assign hazard_a    = busy_all[rs1];
  assign hazard_b    = busy_all[rs2];
  assign unused_bit0 = busy_nx[0];

  // Clear first so a same-index issue set overrides it.
  always_comb begin
    busy_nx = busy_all;
    if (wb_go)
      busy_nx[wb_rd] = 1'b0;
    if (issue_valid && issue_ready)
      busy_nx[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy <= '0;
    else
      busy <= busy_nx[NREG-1:1];
  end
`else
  logic unused_sb;

  assign issue_ready = 1'b1;
  assign hazard_a    = 1'b0;
  assign hazard_b    = 1'b0;
  assign unused_sb   = ^{issue_valid, issue_rd, rs1, rs2};
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter.
// Scoreboard expectations follow WB_SCOREBOARD_EN.
module tb_regfile_writeback_arbiter;

  localparam logic [2:0] REG_WRITE_WORD          = 3'd2;
  localparam logic [2:0] REG_WRITE_BYTE_UNSIGNED = 3'd4;

`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_wb_valid;
  logic        alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic [2:0]  alu_wb_pattern;
  logic        lsu_wb_valid;
  logic        lsu_wb_ready;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic [2:0]  lsu_wb_pattern;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard_a;
  logic        hazard_b;
  logic        wr_enable;
  logic [4:0]  wr_address;
  logic [31:0] wr_data;
  logic [2:0]  write_pattern;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_writeback_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .alu_wb_valid   (alu_wb_valid),
    .alu_wb_ready   (alu_wb_ready),
    .alu_wb_rd      (alu_wb_rd),
    .alu_wb_data    (alu_wb_data),
    .alu_wb_pattern (alu_wb_pattern),
    .lsu_wb_valid   (lsu_wb_valid),
    .lsu_wb_ready   (lsu_wb_ready),
    .lsu_wb_rd      (lsu_wb_rd),
    .lsu_wb_data    (lsu_wb_data),
    .lsu_wb_pattern (lsu_wb_pattern),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_ready    (issue_ready),
    .rs1            (rs1),
    .rs2            (rs2),
    .hazard_a       (hazard_a),
    .hazard_b       (hazard_b),
    .wr_enable      (wr_enable),
    .wr_address     (wr_address),
    .wr_data        (wr_data),
    .write_pattern  (write_pattern)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    alu_wb_valid   = 1'b0;
    alu_wb_rd      = '0;
    alu_wb_data    = '0;
    alu_wb_pattern = '0;
    lsu_wb_valid   = 1'b0;
    lsu_wb_rd      = '0;
    lsu_wb_data    = '0;
    lsu_wb_pattern = '0;
    issue_valid    = 1'b0;
    issue_rd       = '0;
    rs1            = 5'd3;
    rs2            = 5'd3;
    tick();
    alu_wb_valid = 1'b1;
    lsu_wb_valid = 1'b1;
    #1;
    check("rst_alu_ready", 32'(alu_wb_ready), 32'd0);
    check("rst_lsu_ready", 32'(lsu_wb_ready), 32'd0);
    tick();
    alu_wb_valid = 1'b0;
    lsu_wb_valid = 1'b0;
    check("rst_wr_enable", 32'(wr_enable), 32'd0);
    check("rst_wr_address", 32'(wr_address), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_pattern", 32'(write_pattern), 32'd0);
    check("rst_hazard_a", 32'(hazard_a), 32'd0);
    check("rst_hazard_b", 32'(hazard_b), 32'd0);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    reset = 1'b0;
    tick();

    // ALU only
    alu_wb_valid   = 1'b1;
    alu_wb_rd      = 5'hA;
    alu_wb_data    = 32'hABCDEFAB;
    alu_wb_pattern = REG_WRITE_WORD;
    #1;
    check("alu_ready", 32'(alu_wb_ready), 32'd1);
    check("alu_lsu_ready", 32'(lsu_wb_ready), 32'd0);
    tick();
    alu_wb_valid = 1'b0;
    check("alu_wr_enable", 32'(wr_enable), 32'd1);
    check("alu_wr_address", 32'(wr_address), 32'h0A);
    check("alu_wr_data", wr_data, 32'hABCDEFAB);
    check("alu_pattern", 32'(write_pattern), 32'(REG_WRITE_WORD));
    tick();
    check("idle_wr_enable", 32'(wr_enable), 32'd0);
    check("idle_hold_addr", 32'(wr_address), 32'h0A);
    check("idle_hold_data", wr_data, 32'hABCDEFAB);

    // LSU byte load
    lsu_wb_valid   = 1'b1;
    lsu_wb_rd      = 5'hF;
    lsu_wb_data    = 32'hABCDEFFA;
    lsu_wb_pattern = REG_WRITE_BYTE_UNSIGNED;
    #1;
    check("lsu_ready", 32'(lsu_wb_ready), 32'd1);
    check("lsu_alu_ready", 32'(alu_wb_ready), 32'd0);
    tick();
    lsu_wb_valid = 1'b0;
    check("lsu_wr_enable", 32'(wr_enable), 32'd1);
    check("lsu_wr_address", 32'(wr_address), 32'h0F);
    check("lsu_wr_data", wr_data, 32'hABCDEFFA);
    check("lsu_pattern", 32'(write_pattern),
          32'(REG_WRITE_BYTE_UNSIGNED));

    // Contention: ALU wins first, then strict alternation
    alu_wb_valid   = 1'b1;
    alu_wb_rd      = 5'd1;
    alu_wb_data    = 32'h11111111;
    alu_wb_pattern = REG_WRITE_WORD;
    lsu_wb_valid   = 1'b1;
    lsu_wb_rd      = 5'd2;
    lsu_wb_data    = 32'h22222222;
    lsu_wb_pattern = REG_WRITE_BYTE_UNSIGNED;
    for (int i = 0; i < 4; i++) begin
      logic exp_alu;
      exp_alu = (i % 2 == 0);
      #1;
      check("cont_alu_ready", 32'(alu_wb_ready), 32'(exp_alu));
      check("cont_lsu_ready", 32'(lsu_wb_ready), 32'(!exp_alu));
      check("cont_one_ready", 32'(alu_wb_ready && lsu_wb_ready), 32'd0);
      tick();
      check("cont_wr_enable", 32'(wr_enable), 32'd1);
      check("cont_wr_address", 32'(wr_address), exp_alu ? 32'd1 : 32'd2);
      check("cont_wr_data", wr_data,
            exp_alu ? 32'h11111111 : 32'h22222222);
    end
    alu_wb_valid = 1'b0;
    lsu_wb_valid = 1'b0;
    #1;
    check("none_alu_ready", 32'(alu_wb_ready), 32'd0);
    check("none_lsu_ready", 32'(lsu_wb_ready), 32'd0);

    // x0 write is accepted then dropped
    alu_wb_valid = 1'b1;
    alu_wb_rd    = 5'd0;
    alu_wb_data  = 32'hEEEEEEEE;
    #1;
    check("x0_ready", 32'(alu_wb_ready), 32'd1);
    tick();
    alu_wb_valid = 1'b0;
    check("x0_wr_enable", 32'(wr_enable), 32'd0);
    check("x0_data_dropped", wr_data, 32'h22222222);

    // Scoreboard: issue rd=3
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    #1;
    check("iss_ready_free", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0;
    check("iss_hazard_a", 32'(hazard_a), 32'(SB));
    check("iss_hazard_b", 32'(hazard_b), 32'(SB));
    check("iss_ready_busy", 32'(issue_ready), 32'(!SB));
    rs2 = 5'd4;
    #1;
    check("iss_hazard_b_other", 32'(hazard_b), 32'd0);

    // LSU writeback of rd=3 clears busy
    lsu_wb_valid   = 1'b1;
    lsu_wb_rd      = 5'd3;
    lsu_wb_data    = 32'h33333333;
    lsu_wb_pattern = REG_WRITE_WORD;
    tick();
    lsu_wb_valid = 1'b0;
    check("clr_wr_address", 32'(wr_address), 32'd3);
    check("clr_hazard_a", 32'(hazard_a), 32'd0);
    check("clr_issue_ready", 32'(issue_ready), 32'd1);

    // Same-edge set and clear: set wins
    issue_valid  = 1'b1;
    lsu_wb_valid = 1'b1;
    tick();
    issue_valid  = 1'b0;
    lsu_wb_valid = 1'b0;
    check("setwin_wr_enable", 32'(wr_enable), 32'd1);
    check("setwin_hazard_a", 32'(hazard_a), 32'(SB));

    // Reset with busy[3] set and a write in flight
    alu_wb_valid = 1'b1;
    alu_wb_rd    = 5'd7;
    alu_wb_data  = 32'h77777777;
    tick();
    check("mid_wr_enable_pre", 32'(wr_enable), 32'd1);
    check("mid_wr_address_pre", 32'(wr_address), 32'd7);
    reset = 1'b1;
    #1;
    check("mid_alu_ready", 32'(alu_wb_ready), 32'd0);
    check("mid_lsu_ready", 32'(lsu_wb_ready), 32'd0);
    tick();
    check("mid_wr_enable", 32'(wr_enable), 32'd0);
    check("mid_hazard_a", 32'(hazard_a), 32'd0);
    check("mid_wr_address", 32'(wr_address), 32'd0);
    alu_wb_valid = 1'b0;
    reset        = 1'b0;
    tick();
    check("post_wr_enable", 32'(wr_enable), 32'd0);
    check("post_issue_ready", 32'(issue_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
